// File: rtl/id_ex_stage.sv
// -----------------------------------------------------------------------------
// id_ex_stage
//
// Decode / operand-fetch stage and ID/EX pipeline register of a 5-stage MIPS
// datapath. It drives the register file read addresses from the instruction
// in IF/ID, selects each operand (hard-wired $0, same-cycle writeback bypass,
// or register file data), sign-extends the immediate and detects load-use
// hazards against the instruction currently in EX. The decoded packet is
// registered into EX with one cycle of latency.
//
// Ports
//   clk, reset              rising-edge clock, asynchronous active-low reset
//   id_valid/id_instr/id_pc instruction presented by IF/ID
//   flush                   squash the instruction entering EX
//   rf_addr1/rf_addr2       register file read addresses (rs, rt)
//   rf_data1/rf_data2       register file combinational read data
//   wb_we/wb_addr/wb_data   writeback port landing on the same edge
//   stall                   combinational; IF/ID holds this cycle
//   ex_*                    registered instruction packet for EX
//   stall_cnt               saturating count of stall cycles
// -----------------------------------------------------------------------------
module id_ex_stage #(
  parameter int          CNT_W     = 16,
  parameter logic [5:0]  LOAD_OPC  = 6'h23,
  parameter logic [5:0]  STORE_OPC = 6'h2B
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [31:0]      id_instr,
  input  logic [31:0]      id_pc,
  input  logic             flush,
  output logic [4:0]       rf_addr1,
  output logic [4:0]       rf_addr2,
  input  logic [31:0]      rf_data1,
  input  logic [31:0]      rf_data2,
  input  logic             wb_we,
  input  logic [4:0]       wb_addr,
  input  logic [31:0]      wb_data,
  output logic             stall,
  output logic             ex_valid,
  output logic [31:0]      ex_pc,
  output logic [5:0]       ex_opcode,
  output logic [5:0]       ex_funct,
  output logic [31:0]      ex_op1,
  output logic [31:0]      ex_op2,
  output logic [31:0]      ex_imm,
  output logic [4:0]       ex_dest,
  output logic             ex_we,
  output logic             ex_is_load,
  output logic             ex_is_store,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [5:0] OPC_RTYPE = 6'h00;
  localparam logic [5:0] OPC_BEQ   = 6'h04;
  localparam logic [5:0] OPC_ADDI  = 6'h08;
  localparam logic [5:0] OPC_ANDI  = 6'h0C;
  localparam logic [5:0] OPC_ORI   = 6'h0D;

  // Decoded fields of the ID instruction
  logic [5:0]  opcode;
  logic [4:0]  rs, rt, rd;
  logic        uses_rt;
  logic        has_dest;
  logic [4:0]  dest;
  logic        dest_we;
  logic [31:0] op1_sel, op2_sel;
  logic [31:0] imm_sext;

  // Pipeline register state
  logic             ex_valid_q,    ex_valid_d;
  logic [31:0]      ex_pc_q,       ex_pc_d;
  logic [5:0]       ex_opcode_q,   ex_opcode_d;
  logic [5:0]       ex_funct_q,    ex_funct_d;
  logic [31:0]      ex_op1_q,      ex_op1_d;
  logic [31:0]      ex_op2_q,      ex_op2_d;
  logic [31:0]      ex_imm_q,      ex_imm_d;
  logic [4:0]       ex_dest_q,     ex_dest_d;
  logic             ex_we_q,       ex_we_d;
  logic             ex_is_load_q,  ex_is_load_d;
  logic             ex_is_store_q, ex_is_store_d;
  logic [CNT_W-1:0] stall_cnt_q,   stall_cnt_d;

  // Operand select: $0 reads as zero even if something "writes" it, then a
  // writeback to the same register wins over the stale register file value.
  function automatic logic [31:0] operand(input logic [4:0]  addr,
                                          input logic [31:0] rf_val,
                                          input logic        w_en,
                                          input logic [4:0]  w_addr,
                                          input logic [31:0] w_data);
    if (addr == 5'd0)                   return 32'h0;
    else if (w_en && (w_addr == addr))  return w_data;
    else                                return rf_val;
  endfunction

  // NOTE: every signal assigned in always_comb gets a default at the top so
  // no path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    opcode   = id_instr[31:26];
    rs       = id_instr[25:21];
    rt       = id_instr[20:16];
    rd       = id_instr[15:11];
    imm_sext = {{16{id_instr[15]}}, id_instr[15:0]};

    uses_rt  = (opcode == OPC_RTYPE) || (opcode == STORE_OPC) || (opcode == OPC_BEQ);

    has_dest = 1'b0;
    dest     = 5'd0;
    if (opcode == OPC_RTYPE) begin
      has_dest = 1'b1;
      dest     = rd;
    end else if ((opcode == LOAD_OPC) || (opcode == OPC_ADDI) ||
                 (opcode == OPC_ANDI) || (opcode == OPC_ORI)) begin
      has_dest = 1'b1;
      dest     = rt;
    end
    dest_we = id_valid && has_dest && (dest != 5'd0);

    op1_sel = operand(rs, rf_data1, wb_we, wb_addr, wb_data);
    op2_sel = operand(rt, rf_data2, wb_we, wb_addr, wb_data);

    // Load in EX whose result is needed by the instruction in ID: the value
    // only exists after MEM, so ID must wait one cycle.
    stall = id_valid && ex_valid_q && ex_is_load_q && (ex_dest_q != 5'd0) &&
            ((ex_dest_q == rs) || (uses_rt && (ex_dest_q == rt)));
  end

  always_comb begin
    // Default: hold everything; the bubble branches only touch control bits,
    // so data fields keep their last (defined) values.
    ex_valid_d    = ex_valid_q;
    ex_pc_d       = ex_pc_q;
    ex_opcode_d   = ex_opcode_q;
    ex_funct_d    = ex_funct_q;
    ex_op1_d      = ex_op1_q;
    ex_op2_d      = ex_op2_q;
    ex_imm_d      = ex_imm_q;
    ex_dest_d     = ex_dest_q;
    ex_we_d       = ex_we_q;
    ex_is_load_d  = ex_is_load_q;
    ex_is_store_d = ex_is_store_q;
    stall_cnt_d   = stall_cnt_q;

    if (flush || stall) begin
      ex_valid_d    = 1'b0;
      ex_we_d       = 1'b0;
      ex_is_load_d  = 1'b0;
      ex_is_store_d = 1'b0;
      ex_dest_d     = 5'd0;
    end else begin
      ex_valid_d    = id_valid;
      ex_we_d       = dest_we;
      ex_dest_d     = dest_we ? dest : 5'd0;
      ex_is_load_d  = id_valid && (opcode == LOAD_OPC);
      ex_is_store_d = id_valid && (opcode == STORE_OPC);
      // Data fields are only taken from a valid instruction so an idle IF/ID
      // with undriven register reads cannot push X into EX.
      if (id_valid) begin
        ex_pc_d     = id_pc;
        ex_opcode_d = opcode;
        ex_funct_d  = id_instr[5:0];
        ex_op1_d    = op1_sel;
        ex_op2_d    = op2_sel;
        ex_imm_d    = imm_sext;
      end
    end

    // A flushed cycle is not a stall cycle even if the hazard was present.
    if (stall && !flush && (stall_cnt_q != {CNT_W{1'b1}}))
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ex_valid_q    <= 1'b0;
      ex_pc_q       <= 32'h0;
      ex_opcode_q   <= 6'h0;
      ex_funct_q    <= 6'h0;
      ex_op1_q      <= 32'h0;
      ex_op2_q      <= 32'h0;
      ex_imm_q      <= 32'h0;
      ex_dest_q     <= 5'd0;
      ex_we_q       <= 1'b0;
      ex_is_load_q  <= 1'b0;
      ex_is_store_q <= 1'b0;
      stall_cnt_q   <= '0;
    end else begin
      ex_valid_q    <= ex_valid_d;
      ex_pc_q       <= ex_pc_d;
      ex_opcode_q   <= ex_opcode_d;
      ex_funct_q    <= ex_funct_d;
      ex_op1_q      <= ex_op1_d;
      ex_op2_q      <= ex_op2_d;
      ex_imm_q      <= ex_imm_d;
      ex_dest_q     <= ex_dest_d;
      ex_we_q       <= ex_we_d;
      ex_is_load_q  <= ex_is_load_d;
      ex_is_store_q <= ex_is_store_d;
      stall_cnt_q   <= stall_cnt_d;
    end
  end

  assign rf_addr1    = rs;
  assign rf_addr2    = rt;
  assign ex_valid    = ex_valid_q;
  assign ex_pc       = ex_pc_q;
  assign ex_opcode   = ex_opcode_q;
  assign ex_funct    = ex_funct_q;
  assign ex_op1      = ex_op1_q;
  assign ex_op2      = ex_op2_q;
  assign ex_imm      = ex_imm_q;
  assign ex_dest     = ex_dest_q;
  assign ex_we       = ex_we_q;
  assign ex_is_load  = ex_is_load_q;
  assign ex_is_store = ex_is_store_q;
  assign stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// -----------------------------------------------------------------------------
// tb_id_ex_stage
//
// Directed-vector bench for id_ex_stage. Stimulus pushes the hand-computed EX
// packet it expects into a queue; a monitor pops and compares whenever the
// DUT presents ex_valid. A second instance with CNT_W=2 shares all inputs to
// exercise stall counter saturation.
// -----------------------------------------------------------------------------
module tb_id_ex_stage;

  typedef struct {
    logic [31:0] pc;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [31:0] imm;
    logic [4:0]  dest;
    logic        we;
    logic        is_load;
    logic        is_store;
  } pkt_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        id_valid;
  logic [31:0] id_instr, id_pc;
  logic        flush;
  logic [4:0]  rf_addr1, rf_addr2;
  logic [31:0] rf_data1, rf_data2;
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        stall;
  logic        ex_valid;
  logic [31:0] ex_pc, ex_op1, ex_op2, ex_imm;
  logic [5:0]  ex_opcode, ex_funct;
  logic [4:0]  ex_dest;
  logic        ex_we, ex_is_load, ex_is_store;
  logic [15:0] stall_cnt;

  // Saturation instance outputs
  logic [4:0]  s_rf_addr1, s_rf_addr2;
  logic        s_stall, s_ex_valid, s_ex_we, s_ex_is_load, s_ex_is_store;
  logic [31:0] s_ex_pc, s_ex_op1, s_ex_op2, s_ex_imm;
  logic [5:0]  s_ex_opcode, s_ex_funct;
  logic [4:0]  s_ex_dest;
  logic [1:0]  s_stall_cnt;

  int checks = 0;
  int errors = 0;
  pkt_t exp_q[$];

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_instr(id_instr),
    .id_pc(id_pc), .flush(flush), .rf_addr1(rf_addr1), .rf_addr2(rf_addr2),
    .rf_data1(rf_data1), .rf_data2(rf_data2), .wb_we(wb_we),
    .wb_addr(wb_addr), .wb_data(wb_data), .stall(stall),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_opcode(ex_opcode),
    .ex_funct(ex_funct), .ex_op1(ex_op1), .ex_op2(ex_op2), .ex_imm(ex_imm),
    .ex_dest(ex_dest), .ex_we(ex_we), .ex_is_load(ex_is_load),
    .ex_is_store(ex_is_store), .stall_cnt(stall_cnt)
  );

  id_ex_stage #(.CNT_W(2)) dut_sat (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_instr(id_instr),
    .id_pc(id_pc), .flush(flush), .rf_addr1(s_rf_addr1), .rf_addr2(s_rf_addr2),
    .rf_data1(rf_data1), .rf_data2(rf_data2), .wb_we(wb_we),
    .wb_addr(wb_addr), .wb_data(wb_data), .stall(s_stall),
    .ex_valid(s_ex_valid), .ex_pc(s_ex_pc), .ex_opcode(s_ex_opcode),
    .ex_funct(s_ex_funct), .ex_op1(s_ex_op1), .ex_op2(s_ex_op2),
    .ex_imm(s_ex_imm), .ex_dest(s_ex_dest), .ex_we(s_ex_we),
    .ex_is_load(s_ex_is_load), .ex_is_store(s_ex_is_store),
    .stall_cnt(s_stall_cnt)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void push(input logic [31:0] pc, input logic [5:0] opc,
                               input logic [5:0] fn, input logic [31:0] o1,
                               input logic [31:0] o2, input logic [31:0] imm,
                               input logic [4:0] dst, input logic we,
                               input logic ld, input logic st);
    pkt_t p;
    p.pc = pc; p.opcode = opc; p.funct = fn; p.op1 = o1; p.op2 = o2;
    p.imm = imm; p.dest = dst; p.we = we; p.is_load = ld; p.is_store = st;
    exp_q.push_back(p);
  endfunction

  // Monitor: compare every valid EX packet against the scoreboard.
  always @(negedge clk) begin
    if (reset === 1'b1 && ex_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pkt: got pc %h with no expected packet", ex_pc);
      end else begin
        pkt_t e;
        e = exp_q.pop_front();
        check("pkt_pc",       ex_pc,                e.pc);
        check("pkt_opcode",   32'(ex_opcode),       32'(e.opcode));
        check("pkt_funct",    32'(ex_funct),        32'(e.funct));
        check("pkt_op1",      ex_op1,               e.op1);
        check("pkt_op2",      ex_op2,               e.op2);
        check("pkt_imm",      ex_imm,               e.imm);
        check("pkt_dest",     32'(ex_dest),         32'(e.dest));
        check("pkt_we",       32'(ex_we),           32'(e.we));
        check("pkt_is_load",  32'(ex_is_load),      32'(e.is_load));
        check("pkt_is_store", 32'(ex_is_store),     32'(e.is_store));
      end
    end
  end

  // Present one ID cycle, check the combinational stall, then cross the edge.
  task automatic step(input logic v, input logic [31:0] instr, input logic [31:0] pc,
                      input logic [31:0] r1, input logic [31:0] r2,
                      input logic wwe, input logic [4:0] wa, input logic [31:0] wd,
                      input logic fl, input logic exp_stall);
    id_valid = v; id_instr = instr; id_pc = pc;
    rf_data1 = r1; rf_data2 = r2;
    wb_we = wwe; wb_addr = wa; wb_data = wd; flush = fl;
    #1;
    check("stall", 32'(stall), 32'(exp_stall));
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ex_valid"},  32'(ex_valid),    0);
    check({tag, "_ex_pc"},     ex_pc,            0);
    check({tag, "_ex_opcode"}, 32'(ex_opcode),   0);
    check({tag, "_ex_funct"},  32'(ex_funct),    0);
    check({tag, "_ex_op1"},    ex_op1,           0);
    check({tag, "_ex_op2"},    ex_op2,           0);
    check({tag, "_ex_imm"},    ex_imm,           0);
    check({tag, "_ex_dest"},   32'(ex_dest),     0);
    check({tag, "_ex_we"},     32'(ex_we),       0);
    check({tag, "_ex_ld"},     32'(ex_is_load),  0);
    check({tag, "_ex_st"},     32'(ex_is_store), 0);
    check({tag, "_stall"},     32'(stall),       0);
    check({tag, "_stall_cnt"}, 32'(stall_cnt),   0);
    check({tag, "_sat_cnt"},   32'(s_stall_cnt), 0);
  endtask

  localparam logic [31:0] ADD_3_1_2  = 32'h00221820; // add $3,$1,$2
  localparam logic [31:0] ADDI_4_0_M = 32'h2004FFFF; // addi $4,$0,-1
  localparam logic [31:0] LW_5_0_1   = 32'h8C250000; // lw $5,0($1)
  localparam logic [31:0] ADD_6_5_2  = 32'h00A23020; // add $6,$5,$2
  localparam logic [31:0] ADD_6_7_2  = 32'h00E23020; // add $6,$7,$2
  localparam logic [31:0] ADDI_5_1_1 = 32'h20250001; // addi $5,$1,1
  localparam logic [31:0] SW_5_4_1   = 32'hAC250004; // sw $5,4($1)

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; id_valid = 1'b0; id_instr = 32'h0; id_pc = 32'h0;
    flush = 1'b0; rf_data1 = 32'h0; rf_data2 = 32'h0;
    wb_we = 1'b0; wb_addr = 5'd0; wb_data = 32'h0;
    #2;
    check_all_zero("reset");
    @(posedge clk); #1;
    reset = 1'b1;

    // Plain add, no writeback
    id_instr = ADD_3_1_2; #1;
    check("rf_addr1", 32'(rf_addr1), 1);
    check("rf_addr2", 32'(rf_addr2), 2);
    push(32'h100, 6'h00, 6'h20, 32'h5, 32'h7, 32'h1820, 5'd3, 1, 0, 0);
    step(1, ADD_3_1_2, 32'h100, 32'h5, 32'h7, 0, 5'd0, 32'h0, 0, 0);

    // Writeback bypass on rs, then rt, then a write to $0 that must not bypass
    push(32'h104, 6'h00, 6'h20, 32'hAAAA0000, 32'h7, 32'h1820, 5'd3, 1, 0, 0);
    step(1, ADD_3_1_2, 32'h104, 32'h5, 32'h7, 1, 5'd1, 32'hAAAA0000, 0, 0);
    push(32'h108, 6'h00, 6'h20, 32'h5, 32'h12345678, 32'h1820, 5'd3, 1, 0, 0);
    step(1, ADD_3_1_2, 32'h108, 32'h5, 32'h7, 1, 5'd2, 32'h12345678, 0, 0);
    push(32'h10C, 6'h00, 6'h20, 32'h5, 32'h7, 32'h1820, 5'd3, 1, 0, 0);
    step(1, ADD_3_1_2, 32'h10C, 32'h5, 32'h7, 1, 5'd0, 32'hAAAA0000, 0, 0);

    // $0 read stays zero even against a writeback addressed to $0
    push(32'h110, 6'h08, 6'h3F, 32'h0, 32'h55, 32'hFFFFFFFF, 5'd4, 1, 0, 0);
    step(1, ADDI_4_0_M, 32'h110, 32'hDEAD, 32'h55, 1, 5'd0, 32'hBEEF, 0, 0);

    // Load-use: one stall, one bubble, then the add issues
    push(32'h114, 6'h23, 6'h00, 32'h1000, 32'h9, 32'h0, 5'd5, 1, 1, 0);
    step(1, LW_5_0_1, 32'h114, 32'h1000, 32'h9, 0, 5'd0, 32'h0, 0, 0);
    step(1, ADD_6_5_2, 32'h118, 32'h77, 32'h3, 0, 5'd0, 32'h0, 0, 1);
    check("lu_bubble_valid", 32'(ex_valid), 0);
    check("lu_stall_cnt", 32'(stall_cnt), 1);
    push(32'h118, 6'h00, 6'h20, 32'h77, 32'h3, 32'h3020, 5'd6, 1, 0, 0);
    step(1, ADD_6_5_2, 32'h118, 32'h77, 32'h3, 0, 5'd0, 32'h0, 0, 0);

    // Independent add after a load: no stall
    push(32'h11C, 6'h23, 6'h00, 32'h1000, 32'h9, 32'h0, 5'd5, 1, 1, 0);
    step(1, LW_5_0_1, 32'h11C, 32'h1000, 32'h9, 0, 5'd0, 32'h0, 0, 0);
    push(32'h120, 6'h00, 6'h20, 32'h70, 32'h3, 32'h3020, 5'd6, 1, 0, 0);
    step(1, ADD_6_7_2, 32'h120, 32'h70, 32'h3, 0, 5'd0, 32'h0, 0, 0);
    check("nodep_stall_cnt", 32'(stall_cnt), 1);

    // addi only reads rs; rt matching the load dest is not a hazard
    push(32'h124, 6'h23, 6'h00, 32'h1000, 32'h9, 32'h0, 5'd5, 1, 1, 0);
    step(1, LW_5_0_1, 32'h124, 32'h1000, 32'h9, 0, 5'd0, 32'h0, 0, 0);
    push(32'h128, 6'h08, 6'h01, 32'h10, 32'h20, 32'h1, 5'd5, 1, 0, 0);
    step(1, ADDI_5_1_1, 32'h128, 32'h10, 32'h20, 0, 5'd0, 32'h0, 0, 0);

    // Invalid ID instruction after a load: no stall, bubble enters EX
    push(32'h12C, 6'h23, 6'h00, 32'h1000, 32'h9, 32'h0, 5'd5, 1, 1, 0);
    step(1, LW_5_0_1, 32'h12C, 32'h1000, 32'h9, 0, 5'd0, 32'h0, 0, 0);
    step(0, ADD_6_5_2, 32'h130, 32'h77, 32'h3, 0, 5'd0, 32'h0, 0, 0);
    check("idle_bubble_valid", 32'(ex_valid), 0);

    // Flush during a load-use stall: bubble, counter unchanged
    push(32'h134, 6'h23, 6'h00, 32'h1000, 32'h9, 32'h0, 5'd5, 1, 1, 0);
    step(1, LW_5_0_1, 32'h134, 32'h1000, 32'h9, 0, 5'd0, 32'h0, 0, 0);
    step(1, ADD_6_5_2, 32'h138, 32'h77, 32'h3, 0, 5'd0, 32'h0, 1, 1);
    check("flush_bubble_valid", 32'(ex_valid), 0);
    check("flush_stall_cnt", 32'(stall_cnt), 1);
    check("flush_sat_cnt", 32'(s_stall_cnt), 1);

    // Store: no register write
    push(32'h13C, 6'h2B, 6'h04, 32'h2000, 32'hCAFE, 32'h4, 5'd0, 0, 0, 1);
    step(1, SW_5_4_1, 32'h13C, 32'h2000, 32'hCAFE, 0, 5'd0, 32'h0, 0, 0);

    // Repeated load-use pairs: 16-bit counter keeps counting, 2-bit saturates
    for (int k = 1; k <= 5; k++) begin
      logic [31:0] base;
      base = 32'h200 + 32'(k) * 32'h10;
      push(base, 6'h23, 6'h00, 32'h1000, 32'h9, 32'h0, 5'd5, 1, 1, 0);
      step(1, LW_5_0_1, base, 32'h1000, 32'h9, 0, 5'd0, 32'h0, 0, 0);
      step(1, ADD_6_5_2, base + 4, 32'h77, 32'h3, 0, 5'd0, 32'h0, 0, 1);
      push(base + 4, 6'h00, 6'h20, 32'h77, 32'h3, 32'h3020, 5'd6, 1, 0, 0);
      step(1, ADD_6_5_2, base + 4, 32'h77, 32'h3, 0, 5'd0, 32'h0, 0, 0);
      check("sat_stall_cnt16", 32'(stall_cnt), 32'(1 + k));
      check("sat_stall_cnt2", 32'(s_stall_cnt), (1 + k > 3) ? 32'd3 : 32'(1 + k));
    end

    // Asynchronous reset in the middle of a stall cycle
    push(32'h300, 6'h23, 6'h00, 32'h1000, 32'h9, 32'h0, 5'd5, 1, 1, 0);
    step(1, LW_5_0_1, 32'h300, 32'h1000, 32'h9, 0, 5'd0, 32'h0, 0, 0);
    @(negedge clk); #1;
    id_valid = 1'b1; id_instr = ADD_6_5_2; id_pc = 32'h304;
    #1;
    check("pre_reset_stall", 32'(stall), 1);
    reset = 1'b0;
    #1;
    check_all_zero("async_reset");
    @(posedge clk); #1;
    id_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    check("post_reset_valid", 32'(ex_valid), 0);

    check("queue_drained", 32'(exp_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Decode/operand-fetch stage and ID/EX pipeline register of the 5-stage MIPS datapath.
- Drives the register file read addresses and captures its combinational read data.
- Bypasses a same-cycle writeback, sign-extends the immediate, and detects load-use hazards.
- Issues a registered instruction packet to EX with one-cycle latency.

Parameters:
- CNT_W, 16, width of the saturating stall counter
- LOAD_OPC, 6'h23, opcode treated as load (lw)
- STORE_OPC, 6'h2B, opcode treated as store (sw)

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- id_valid  input  1  IF/ID holds a valid instruction
- id_instr  input  32  instruction from IF/ID
- id_pc  input  32  PC of id_instr
- flush  input  1  branch/jump taken; squash the instruction entering EX
- rf_addr1  output  5  register file read address 1 (= id_instr[25:21])
- rf_addr2  output  5  register file read address 2 (= id_instr[20:16])
- rf_data1  input  32  register file read data 1
- rf_data2  input  32  register file read data 2
- wb_we  input  1  writeback write enable (same signals as the register file write port)
- wb_addr  input  5  writeback destination
- wb_data  input  32  writeback data
- stall  output  1  combinational; IF/ID must hold its contents this cycle
- ex_valid  output  1  EX packet valid
- ex_pc  output  32  registered PC
- ex_opcode  output  6  registered instr[31:26]
- ex_funct  output  6  registered instr[5:0]
- ex_op1  output  32  registered rs operand
- ex_op2  output  32  registered rt operand
- ex_imm  output  32  registered sign-extended instr[15:0]
- ex_dest  output  5  registered destination register
- ex_we  output  1  registered register-write flag
- ex_is_load  output  1  opcode == LOAD_OPC
- ex_is_store  output  1  opcode == STORE_OPC
- stall_cnt  output  CNT_W  saturating count of stall cycles

Behaviour:
- Reset (reset=0, asynchronous): all ex_* outputs = 0 and stall_cnt = 0. stall = 0 because ex_valid = 0.
- Decode fields: rs=[25:21], rt=[20:16], rd=[15:11].
  - uses_rt = (opcode==0) | (opcode==STORE_OPC) | (opcode==6'h04).
  - Destination: opcode 0 -> rd. Opcode in {LOAD_OPC, 6'h08, 6'h0C, 6'h0D} -> rt. Otherwise no write.
  - ex_we = id_valid & has_dest & (dest != 0). ex_dest = 0 when ex_we = 0.
- Operand select, per port, in priority order:
  1. Address == 0 -> 32'h0.
  2. wb_we & (wb_addr == address) -> wb_data (bypasses the register file write landing on the same edge).
  3. Otherwise -> rf_data.
  - Never pass X from rf_data onward when wb_we is low; only the selected value is registered.
- ex_imm = {{16{instr[15]}}, instr[15:0]}.
- stall = id_valid & ex_valid & ex_is_load & (ex_dest != 0) & ((ex_dest == rs) | (uses_rt & (ex_dest == rt))).
- Register update on each rising edge, in priority order:
  1. flush = 1: load a bubble (ex_valid=0, ex_we=0, ex_is_load=0, ex_is_store=0, ex_dest=0). stall is ignored that cycle.
  2. stall = 1: load a bubble. The ID instruction is re-presented next cycle by the held IF/ID register.
  3. Otherwise: capture the decoded packet. ex_valid = id_valid.
- Bubble data fields (pc, op1, op2, imm, opcode, funct) hold their previous values; they are don't-care but must not go X.
- Latency: ID to EX is exactly 1 cycle. A load-use costs exactly 1 bubble, because the EX load moves on and the stall clears the next cycle.
- stall_cnt: increments on each edge where stall=1 and flush=0. It saturates at all-ones with no wrap, and is cleared only by reset.
- id_valid = 0: stall = 0, and a bubble enters EX.
- Reset asserted mid-stall: outputs clear immediately; no pending state survives.

Test Plan:
- Reset, then id_instr=add $3,$1,$2 (32'h00221820), rf_data1=5, rf_data2=7, no wb -> next cycle ex_valid=1, ex_op1=5, ex_op2=7, ex_dest=3, ex_we=1.
- Bypass: same add with wb_we=1, wb_addr=1, wb_data=32'hAAAA0000, rf_data1=5 -> ex_op1=32'hAAAA0000. With wb_addr=0 instead -> ex_op1=5.
- $0 read: addi $4,$0,-1 (32'h2004FFFF), rf_data1=32'hDEAD -> ex_op1=0, ex_imm=32'hFFFFFFFF, ex_dest=4, ex_we=1.
- Load-use: lw $5,0($1), then add $6,$5,$2 -> stall=1 for exactly one cycle, then a bubble (ex_valid=0), then add issues. stall_cnt=1. Repeat with add $6,$7,$2 -> no stall.
- Flush during stall: load-use condition plus flush=1 -> bubble, stall_cnt unchanged. Non-writing sw -> ex_we=0, ex_dest=0, ex_is_store=1.
- Saturation: CNT_W=2, hold the load-use condition for 5 cycles -> stall_cnt reaches 3 and stays there. Assert reset asynchronously mid-cycle -> all outputs 0 before the next edge.
